maxnet_sequencer: RTL and testbench

//  Iteration sequencer for the 4-neuron Maxnet datapath: loads X1..X4, runs lateral-inhibition

---
 rtl/maxnet_pkg.sv | 16 +
 rtl/maxnet_winner_enc.sv | 18 +
 rtl/maxnet_sequencer.sv | 112 +++++++++++
 tb/tb_maxnet_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet sequencer, its winner encoder and the datapath.
package maxnet_pkg;

    localparam int NEURONS          = 4;
    localparam int IDX_W            = 2;
    localparam int MAX_ITER_DEFAULT = 15;
    localparam int ITER_W_DEFAULT   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/maxnet_winner_enc.sv
// Lowest-set-bit priority encoder: maps the per-neuron active flags to a winner index.
module maxnet_winner_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] active,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last assignment to win.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (active[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/maxnet_sequencer.sv
// Iteration sequencer for the Maxnet datapath: load, inhibition passes, winner/timeout report.
//  state  | meaning
//  S_IDLE | waiting for start, datapath untouched
//  S_LOAD | one cycle writing X inputs into every neuron
//  S_ITER | one inhibition pass per cycle until complete or iteration limit
//  S_DONE | results held until start is released
module maxnet_sequencer
    import maxnet_pkg::*;
#(
    parameter int N_NEURONS = NEURONS,
    parameter int MAX_ITER  = MAX_ITER_DEFAULT,
    parameter int ITER_W    = ITER_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 complete,
    input  logic [N_NEURONS-1:0] active,
    output logic                 sel,
    output logic [N_NEURONS-1:0] en,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 winner_valid,
    output logic [IDX_W-1:0]     winner_idx,
    output logic [ITER_W-1:0]    iter_count
);

    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    seq_state_e        state_q;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              timeout_q;
    logic              winner_valid_q;
    logic [IDX_W-1:0]  winner_idx_q;
    logic [IDX_W-1:0]  enc_idx;
    logic              at_limit;

    maxnet_winner_enc #(
        .N (N_NEURONS),
        .W (IDX_W)
    ) u_winner_enc (
        .active (active),
        .idx    (enc_idx)
    );

    assign at_limit = (iter_q == ITER_LIMIT);
    // Saturate rather than wrap; the limit check normally stops the count first anyway.
    assign iter_d   = at_limit ? iter_q : iter_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            iter_q         <= '0;
            timeout_q      <= 1'b0;
            winner_valid_q <= 1'b0;
            winner_idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q        <= S_LOAD;
                        iter_q         <= '0;
                        timeout_q      <= 1'b0;
                        winner_valid_q <= 1'b0;
                        winner_idx_q   <= '0;
                    end
                end
                S_LOAD: state_q <= S_ITER;
                S_ITER: begin
                    if (complete) begin
                        state_q        <= S_DONE;
                        winner_valid_q <= |active;
                        winner_idx_q   <= enc_idx;
                    end else if (at_limit) begin
                        state_q        <= S_DONE;
                        timeout_q      <= 1'b1;
                        winner_valid_q <= 1'b0;
                    end else begin
                        iter_q <= iter_d;
                    end
                end
                S_DONE: begin
                    if (!start) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Mealy controls: enables react to the datapath flags within the same cycle.
    always_comb begin
        sel = 1'b0;
        en  = '0;
        case (state_q)
            S_LOAD: en = '1;
            S_ITER: begin
                sel = 1'b1;
                if (!complete && !at_limit) en = active;
            end
            default: ;
        endcase
    end

    assign busy         = (state_q == S_LOAD) || (state_q == S_ITER);
    assign done         = (state_q == S_DONE);
    assign timeout      = timeout_q;
    assign winner_valid = winner_valid_q;
    assign winner_idx   = winner_idx_q;
    assign iter_count   = iter_q;

endmodule

// File: tb/tb_maxnet_sequencer.sv
// Self-checking bench: behavioural datapath drives the sequencer, pass-level reference predicts results.
module tb_maxnet_sequencer;

    localparam int MAXI = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       complete;
    logic [3:0] active;
    logic       sel;
    logic [3:0] en;
    logic       busy, done, timeout, winner_valid;
    logic [1:0] winner_idx;
    logic [3:0] iter_count;

    int checks = 0;
    int errors = 0;

    // Datapath model and override for hand-forced flag patterns
    int         dp_x [4];
    int         tb_x [4];
    int         dp_sum;
    logic [3:0] dp_act;
    logic       ovr = 1'b0;
    logic [3:0] ovr_active = '0;
    logic       ovr_complete = 1'b0;

    // Reference results for one run
    int         rx [4];
    int         r_pass;
    bit         r_to, r_wv;
    int         r_widx;
    logic [3:0] r_en [16];

    maxnet_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .complete     (complete),
        .active       (active),
        .sel          (sel),
        .en           (en),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .winner_valid (winner_valid),
        .winner_idx   (winner_idx),
        .iter_count   (iter_count)
    );

    always #5 clk = ~clk;

    function automatic int inh_val(input int self_v, input int total);
        int r;
        r = self_v - (total - self_v) / 8;
        return (r < 0) ? 0 : r;
    endfunction

    always_comb begin
        dp_sum = 0;
        dp_act = '0;
        for (int i = 0; i < 4; i++) begin
            dp_sum += dp_x[i];
            if (dp_x[i] != 0) dp_act[i] = 1'b1;
        end
    end

    assign active   = ovr ? ovr_active : dp_act;
    assign complete = ovr ? ovr_complete : ($countones(dp_act) <= 1);

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (en[i]) dp_x[i] <= sel ? inh_val(dp_x[i], dp_sum) : tb_x[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-vector view of the run: keep applying inhibition until at most one neuron is nonzero.
    task automatic ref_compute();
        int v [4];
        int nv [4];
        int s, cnt;
        logic [3:0] act;
        v = rx;
        r_to = 0; r_wv = 0; r_widx = 0; r_pass = 0;
        for (int k = 0; k <= MAXI; k++) begin
            act = '0; cnt = 0; s = 0;
            for (int i = 0; i < 4; i++) begin
                s += v[i];
                if (v[i] != 0) begin act[i] = 1'b1; cnt++; end
            end
            if (cnt <= 1) begin
                r_pass = k;
                r_wv   = (cnt == 1);
                for (int i = 3; i >= 0; i--) if (act[i]) r_widx = i;
                return;
            end
            if (k == MAXI) begin
                r_pass = MAXI;
                r_to   = 1;
                return;
            end
            r_en[k] = act;
            for (int i = 0; i < 4; i++) nv[i] = inh_val(v[i], s);
            v = nv;
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic start_and_check_load(input string tag);
        cyc(); start = 1'b1;
        cyc(); start = 1'b0;
        @(negedge clk);
        chk({tag, ".load_en"}, en, 4'b1111);
        chk({tag, ".load_sel"}, sel, 1'b0);
        chk({tag, ".load_busy"}, busy, 1'b1);
        chk({tag, ".load_done"}, done, 1'b0);
    endtask

    task automatic run_check(input string tag, input int x0, input int x1, input int x2,
                             input int x3, input bit toggle);
        rx[0] = x0; rx[1] = x1; rx[2] = x2; rx[3] = x3;
        tb_x = rx;
        ref_compute();
        start_and_check_load(tag);
        for (int k = 0; k <= r_pass; k++) begin
            cyc();
            start = toggle ? ((k == r_pass) ? 1'b1 : k[0]) : 1'b0;
            @(negedge clk);
            chk({tag, ".iter_sel"}, sel, 1'b1);
            chk({tag, ".iter_busy"}, busy, 1'b1);
            chk({tag, ".iter_count"}, iter_count, k);
            chk({tag, ".iter_en"}, en, (k < r_pass) ? r_en[k] : 4'b0000);
        end
        cyc();
        @(negedge clk);
        chk({tag, ".done"}, done, 1'b1);
        chk({tag, ".busy_at_done"}, busy, 1'b0);
        chk({tag, ".timeout"}, timeout, r_to);
        chk({tag, ".winner_valid"}, winner_valid, r_wv);
        if (r_wv) chk({tag, ".winner_idx"}, winner_idx, r_widx);
        chk({tag, ".final_iter"}, iter_count, r_pass);
        if (toggle) begin
            for (int h = 0; h < 3; h++) begin
                cyc();
                @(negedge clk);
                chk({tag, ".hold_done"}, done, 1'b1);
                chk({tag, ".hold_iter"}, iter_count, r_pass);
                chk({tag, ".hold_en"}, en, 4'b0000);
            end
        end
        cyc(); start = 1'b0;
        cyc();
        @(negedge clk);
        chk({tag, ".idle_done"}, done, 1'b0);
        chk({tag, ".idle_busy"}, busy, 1'b0);
        chk({tag, ".idle_en"}, en, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.sel", sel, 1'b0);
        chk("rst.en", en, 4'b0000);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.timeout", timeout, 1'b0);
        chk("rst.wv", winner_valid, 1'b0);
        chk("rst.widx", winner_idx, 2'd0);
        chk("rst.iter", iter_count, 4'd0);
        rst = 1'b1;

        // Reset in the middle of a run at iter_count 3
        tb_x[0] = 17; tb_x[1] = 17; tb_x[2] = 0; tb_x[3] = 0;
        start_and_check_load("midrst");
        for (int k = 0; k <= 3; k++) begin
            cyc();
            @(negedge clk);
            chk("midrst.iter", iter_count, k);
        end
        rst = 1'b0;
        #1;
        chk("midrst.en", en, 4'b0000);
        chk("midrst.sel", sel, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.done", done, 1'b0);
        chk("midrst.iter0", iter_count, 4'd0);
        chk("midrst.timeout", timeout, 1'b0);
        chk("midrst.wv", winner_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk("midrst.idle_busy", busy, 1'b0);
        chk("midrst.idle_en", en, 4'b0000);

        run_check("spread", 5, 10, 20, 31, 1'b0);
        run_check("resolved", 0, 0, 7, 0, 1'b0);
        run_check("tie", 17, 17, 0, 0, 1'b0);

        // A pass that inhibits every neuron at once
        ovr = 1'b1; ovr_active = 4'b0110; ovr_complete = 1'b0;
        start_and_check_load("allzero");
        cyc();
        @(negedge clk);
        chk("allzero.en_pass", en, 4'b0110);
        cyc(); ovr_active = 4'b0000; ovr_complete = 1'b1;
        @(negedge clk);
        chk("allzero.en_final", en, 4'b0000);
        cyc();
        @(negedge clk);
        chk("allzero.done", done, 1'b1);
        chk("allzero.wv", winner_valid, 1'b0);
        chk("allzero.timeout", timeout, 1'b0);
        chk("allzero.iter", iter_count, 4'd1);
        cyc(); ovr = 1'b0;
        cyc();
        @(negedge clk);
        chk("allzero.idle", done, 1'b0);

        // Handshake: start toggled while busy, held in DONE, then a fresh run
        run_check("handshake", 3, 25, 9, 12, 1'b1);
        run_check("restart", 40, 2, 2, 2, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_check("rand", int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), n[2]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
